alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Initiator side of the ALU command interface: accepts operation requests on a valid/ready handshake and drives alu_a / alu_b / alu_op into the 4-bit ALU.
- Holds operands and opcode stable for LAT cycles to cover the ALU's internal adder pipeline.
- Captures the ALU's out/flag and returns them on a valid/ready response channel.
- Sits between the test/control logic and the ALU; one operation in flight at a time.

Parameters:
WIDTH, 4, operand/result width; must equal the ALU's WIDTH.
LAT, 2, cycles opcode and operands are held at the ALU; range 1..15; default covers the registered adder plus the ALU output register.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_op  input  2  opcode: OFF=0, ADD=1, SUB=2, NO_OP=3
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
alu_op  output  2  opcode to ALU
alu_a  output  WIDTH  operand A to ALU
alu_b  output  WIDTH  operand B to ALU
alu_out  input  WIDTH  ALU result
alu_flag  input  1  ALU carry/borrow flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_out  output  WIDTH  captured result
rsp_flag  output  1  captured flag
busy  output  1  high in any state other than IDLE
done_count  output  CNT_W  completed (handshaken) responses; wraps modulo 2^CNT_W

Behaviour:
- All outputs are registered. Reset (rst=1 at a clk edge) forces:
  - state=IDLE
  - alu_op=NO_OP (3), alu_a=0, alu_b=0
  - rsp_valid=0, rsp_out=0, rsp_flag=0
  - done_count=0, busy=0
  - req_ready=1 from the first cycle after reset deasserts
- Reset asserted mid-operation aborts the operation: no response, done_count not incremented.
- FSM states and transitions:
  - IDLE: req_ready=1; alu_op=NO_OP; alu_a/alu_b hold their last values. On req_valid&&req_ready at edge E0: latch req_op/req_a/req_b into alu_op/alu_a/alu_b, load cnt=LAT-1, go to DRIVE.
  - DRIVE: req_ready=0; alu_* held stable. If cnt==0 go to CAPTURE, else cnt decrements. DRIVE lasts exactly LAT cycles.
  - CAPTURE: one cycle; alu_op=NO_OP so the ALU holds its result; operands unchanged. At the end of the cycle, alu_out→rsp_out and alu_flag→rsp_flag, rsp_valid←1, go to RESP.
  - RESP: rsp_valid=1; rsp_out/rsp_flag stable until the handshake. On rsp_valid&&rsp_ready: rsp_valid←0, done_count++, go to IDLE. rsp_ready may be held low indefinitely; alu_op stays NO_OP meanwhile.
- Latency: rsp_valid rises LAT+2 cycles after E0 (4 cycles at default LAT). The next request can be accepted no earlier than the cycle after the response handshake.
- req_ready is low in DRIVE/CAPTURE/RESP. Requests presented then are not consumed; the requester must hold them.
- NO_OP request is a legal transaction: returns the ALU's held previous out/flag.
- OFF request returns out=0, flag=0.
- No arithmetic inside the block; results pass through unmodified. done_count wraps 2^CNT_W-1 → 0.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OFF/ADD/SUB/NO_OP (0..3), 2 bits wide
  - FSM state encoding IDLE/DRIVE/CAPTURE/RESP
  - the ALU uses the same opcode constants
- Single module; no sub-module. For verification, pair the block with the ALU in a top-level bench.

Test Plan:
- Reset: rst held 3 cycles then released → alu_op=3, rsp_valid=0, done_count=0, req_ready=1 one cycle later.
- ADD A=9, B=8 with ALU attached → rsp_valid exactly 4 cycles after accept, rsp_out=1, rsp_flag=1; done_count=1 after the handshake.
- SUB A=3, B=5 → rsp_out=2, rsp_flag=1. SUB A=7, B=2 → rsp_out=5, rsp_flag=0. Back-to-back with req_valid held high: second accept occurs the cycle after the first response handshake.
- Back-pressure: ADD 5+6 with rsp_ready=0 for 10 cycles → rsp_valid=1, rsp_out=11, rsp_flag=0 stable throughout, alu_op=3, req_ready=0; done_count increments only on the cycle rsp_ready=1.
- Reset mid-op: assert rst during DRIVE of SUB 9-1 → no rsp_valid, done_count=0, state IDLE. Then OFF request → rsp_out=0, rsp_flag=0.
- Counter wrap with CNT_W=2: 5 OFF transactions → done_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode and sequencer-state encodings shared by the ALU and its command sequencer.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_OFF   = 2'd0,
        OP_ADD   = 2'd1,
        OP_SUB   = 2'd2,
        OP_NO_OP = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Drives one ALU operation at a time: operands held LAT cycles, result captured and returned
// on a valid/ready response channel; requests stall (req_ready low) until the response handshakes.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LAT   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_flag,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    seq_state_t state;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_op     <= OP_NO_OP;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_out    <= '0;
            rsp_flag   <= 1'b0;
            done_count <= '0;
            busy       <= 1'b0;
            req_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        alu_op    <= req_op;
                        alu_a     <= req_a;
                        alu_b     <= req_b;
                        cnt       <= 4'(LAT - 1);
                        state     <= DRIVE;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        req_ready <= 1'b1;
                        alu_op    <= OP_NO_OP;
                    end
                end
                DRIVE: begin
                    // NO_OP during capture keeps the ALU output register from moving.
                    if (cnt == 4'd0) begin
                        state  <= CAPTURE;
                        alu_op <= OP_NO_OP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    rsp_out   <= alu_out;
                    rsp_flag  <= alu_flag;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        done_count <= done_count + CNT_W'(1);
                        state      <= IDLE;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Sequencer paired with a behavioural two-stage ALU; a second instance with a 2-bit counter
// exercises done_count wrap.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 4;
    localparam int LAT   = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, rsp_valid, rsp_ready, rsp_flag, busy;
    logic [1:0]       req_op, alu_op;
    logic [WIDTH-1:0] req_a, req_b, alu_a, alu_b, alu_out, rsp_out;
    logic             alu_flag;
    logic [CNT_W-1:0] done_count;

    logic             w_req_valid, w_req_ready, w_rsp_valid, w_rsp_ready, w_rsp_flag, w_busy;
    logic [1:0]       w_req_op, w_alu_op;
    logic [WIDTH-1:0] w_alu_a, w_alu_b, w_rsp_out;
    logic [1:0]       w_done_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             flag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_flag(rsp_flag),
        .busy(busy), .done_count(done_count)
    );

    alu_cmd_sequencer #(.WIDTH(WIDTH), .LAT(LAT), .CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_op(w_req_op), .req_a(4'd0), .req_b(4'd0),
        .alu_op(w_alu_op), .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_out(4'd0), .alu_flag(1'b0),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_out(w_rsp_out), .rsp_flag(w_rsp_flag),
        .busy(w_busy), .done_count(w_done_count)
    );

    // ALU: registered add/sub stage then output register; SUB yields |a-b| with borrow flag.
    logic [WIDTH-1:0] s_out;
    logic             s_flag;
    always @(posedge clk) begin
        if (rst) begin
            s_out <= '0; s_flag <= 1'b0; alu_out <= '0; alu_flag <= 1'b0;
        end else begin
            case (alu_op)
                OP_OFF: begin s_out <= '0; s_flag <= 1'b0; end
                OP_ADD: {s_flag, s_out} <= {1'b0, alu_a} + {1'b0, alu_b};
                OP_SUB: begin
                    if (alu_a >= alu_b) begin s_out <= alu_a - alu_b; s_flag <= 1'b0; end
                    else                begin s_out <= alu_b - alu_a; s_flag <= 1'b1; end
                end
                default: ;
            endcase
            alu_out  <= s_out;
            alu_flag <= s_flag;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic put_req(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           output bit ok);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin ok = 1'b1; @(negedge clk); break; end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    // Counts sample points from the one after the accept cycle (=1) until rsp_valid is seen.
    task automatic wait_rsp(output int cyc, output bit ok);
        cyc = 1; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk); cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (alu_op !== 2'd3 || alu_a !== 4'd0 || alu_b !== 4'd0) begin
            errors++; $display("FAIL reset_alu: op=%0d a=%0d b=%0d want op=3 a=0 b=0", alu_op, alu_a, alu_b);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_out !== 4'd0 || rsp_flag !== 1'b0 || busy !== 1'b0 || done_count !== 8'd0) begin
            errors++; $display("FAIL reset_rsp: valid=%b out=%0d flag=%b busy=%b done=%0d want all 0",
                               rsp_valid, rsp_out, rsp_flag, busy, done_count);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: req_ready=%b want 1", req_ready); end
    endtask

    task automatic test_add();
        exp_t e; int cyc; bit ok;
        sb.push_back('{4'd1, 1'b1});
        put_req(OP_ADD, 4'd9, 4'd8, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL add_accept: accepted=%b want 1", ok); end
        wait_rsp(cyc, ok);
        checks++;
        if (!ok || cyc != LAT + 2) begin
            errors++; $display("FAIL add_latency: valid=%b after %0d cycles want %0d", ok, cyc, LAT + 2);
        end
        e = sb.pop_front();
        checks++;
        if (rsp_out !== e.out || rsp_flag !== e.flag) begin
            errors++; $display("FAIL add_result: out=%0d flag=%b want out=%0d flag=%b", rsp_out, rsp_flag, e.out, e.flag);
        end
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
        checks++;
        if (done_count !== 8'd1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL add_done: done=%0d valid=%b want done=1 valid=0", done_count, rsp_valid);
        end
    endtask

    task automatic test_sub_noop();
        logic [1:0]       t_op [3];
        logic [WIDTH-1:0] t_a [3], t_b [3], t_out [3];
        logic             t_flag [3];
        exp_t e; int cyc; bit ok, ok2;
        t_op[0] = OP_SUB;   t_a[0] = 4'd3; t_b[0] = 4'd5; t_out[0] = 4'd2; t_flag[0] = 1'b1;
        t_op[1] = OP_SUB;   t_a[1] = 4'd7; t_b[1] = 4'd2; t_out[1] = 4'd5; t_flag[1] = 1'b0;
        t_op[2] = OP_NO_OP; t_a[2] = 4'd1; t_b[2] = 4'd1; t_out[2] = 4'd5; t_flag[2] = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{t_out[i], t_flag[i]});
            put_req(t_op[i], t_a[i], t_b[i], ok);
            wait_rsp(cyc, ok2);
            e = sb.pop_front();
            checks++;
            if (!ok || !ok2 || rsp_out !== e.out || rsp_flag !== e.flag) begin
                errors++; $display("FAIL op_result[%0d]: ok=%b/%b out=%0d flag=%b want out=%0d flag=%b",
                                   i, ok, ok2, rsp_out, rsp_flag, e.out, e.flag);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e; int cyc; bit ok;
        sb.push_back('{4'd2, 1'b1});
        sb.push_back('{4'd5, 1'b0});
        rsp_ready = 1'b1;
        put_req(OP_SUB, 4'd3, 4'd5, ok);
        // Second request presented immediately and held; must not be taken while busy.
        req_valid = 1'b1; req_op = OP_ADD; req_a = 4'd2; req_b = 4'd3;
        wait_rsp(cyc, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || rsp_out !== e.out || rsp_flag !== e.flag || alu_a !== 4'd3) begin
            errors++; $display("FAIL b2b_first: out=%0d flag=%b alu_a=%0d want out=%0d flag=%b alu_a=3",
                               rsp_out, rsp_flag, alu_a, e.out, e.flag);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_ready: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (alu_op !== 2'd1 || alu_a !== 4'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: alu_op=%0d alu_a=%0d busy=%b want 1/2/1", alu_op, alu_a, busy);
        end
        wait_rsp(cyc, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || cyc != LAT + 2 || rsp_out !== e.out || rsp_flag !== e.flag) begin
            errors++; $display("FAIL b2b_second: cyc=%0d out=%0d flag=%b want cyc=%0d out=%0d flag=%b",
                               cyc, rsp_out, rsp_flag, LAT + 2, e.out, e.flag);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e; int cyc; bit ok; bit bad; logic [CNT_W-1:0] dc0;
        dc0 = done_count;
        sb.push_back('{4'd11, 1'b0});
        rsp_ready = 1'b0;
        put_req(OP_ADD, 4'd5, 4'd6, ok);
        wait_rsp(cyc, ok);
        e = sb.pop_front();
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_out !== e.out || rsp_flag !== e.flag || alu_op !== 2'd3 ||
                req_ready !== 1'b0 || done_count !== dc0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!ok || bad) begin
            errors++; $display("FAIL bp_hold: valid=%b out=%0d flag=%b op=%0d rdy=%b done=%0d want 1/%0d/%b/3/0/%0d",
                               rsp_valid, rsp_out, rsp_flag, alu_op, req_ready, done_count, e.out, e.flag, dc0);
        end
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
        checks++;
        if (done_count !== 8'(dc0 + 1) || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_done: done=%0d valid=%b want %0d/0", done_count, rsp_valid, 8'(dc0 + 1));
        end
    endtask

    task automatic test_reset_midop();
        exp_t e; int cyc; bit ok; bit seen;
        put_req(OP_SUB, 4'd9, 4'd1, ok);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen || done_count !== 8'd0 || busy !== 1'b0 || alu_op !== 2'd3) begin
            errors++; $display("FAIL midop_abort: rsp_seen=%b done=%0d busy=%b op=%0d want 0/0/0/3",
                               seen, done_count, busy, alu_op);
        end
        sb.push_back('{4'd0, 1'b0});
        put_req(OP_OFF, 4'd6, 4'd4, ok);
        wait_rsp(cyc, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || rsp_out !== e.out || rsp_flag !== e.flag) begin
            errors++; $display("FAIL off_result: out=%0d flag=%b want out=%0d flag=%b", rsp_out, rsp_flag, e.out, e.flag);
        end
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    endtask

    task automatic test_counter_wrap();
        logic [1:0] wrap_exp [5];
        bit ok;
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
        w_rsp_ready = 1'b1; w_req_op = OP_OFF; w_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                if (w_rsp_valid) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            @(negedge clk);
            checks++;
            if (!ok || w_done_count !== wrap_exp[i]) begin
                errors++; $display("FAIL wrap[%0d]: rsp=%b done=%0d want %0d", i, ok, w_done_count, wrap_exp[i]);
            end
        end
        w_req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        w_req_valid = 1'b0; w_req_op = 2'd0; w_rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub_noop();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
